// File: rtl/scroll_background_engine_if.sv
// Pixel request/response and texture ROM bus of the scrolling background engine.
// req_valid is a strobe with no back-pressure (every request is accepted); pixel_valid
// and tex_rd are one-cycle strobes, and tex_data must follow tex_addr by one cycle.
interface scroll_background_engine_if #(
  parameter int COORD_W = 11,
  parameter int ADDR_W  = 12
);
  logic               req_valid;
  logic [COORD_W-1:0] requested_x;
  logic [COORD_W-1:0] requested_y;
  logic [ADDR_W-1:0]  tex_addr;
  logic               tex_rd;
  logic [7:0]         tex_data;
  logic               pixel_valid;
  logic [7:0]         output_color;

  modport slave (
    input  req_valid, requested_x, requested_y, tex_data,
    output tex_addr, tex_rd, pixel_valid, output_color
  );

  modport master (
    output req_valid, requested_x, requested_y, tex_data,
    input  tex_addr, tex_rd, pixel_valid, output_color
  );
endinterface

// File: rtl/scroll_background_engine.sv
// Vertical-scrolling tiled background: per-frame fixed-point scroll accumulator and a
// fixed 3-cycle pixel -> texel -> colour pipeline around a 1-cycle-latency texture ROM.
module scroll_background_engine #(
  parameter int         COORD_W    = 11,
  parameter int         SPEED_W    = 10,
  parameter int         SPEED_FRAC = 7,
  parameter int         TEX_W      = 128,
  parameter int         TEX_H      = 32,
  parameter int         SCALE_LOG2 = 2,
  parameter int         WIN_X0     = 32,
  parameter int         WIN_W      = 512,
  parameter logic [7:0] MASK_VALUE = 8'h62
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                frame_start,
  input  logic                scroll_en,
  input  logic [SPEED_W-1:0]  player_speed,
  input  logic                load_scroll,
  input  logic [COORD_W-1:0]  load_value,
  output logic [COORD_W-1:0]  scroll_y,
  scroll_background_engine_if.slave bus
);
  localparam int ACC_W  = COORD_W + SPEED_FRAC;
  localparam int ADDR_W = $clog2(TEX_W * TEX_H);
  localparam int U_W    = $clog2(TEX_W);
  localparam int V_W    = $clog2(TEX_H);
  localparam logic [COORD_W:0] WIN_LO = (COORD_W+1)'(WIN_X0);
  localparam logic [COORD_W:0] WIN_HI = (COORD_W+1)'(WIN_X0 + WIN_W);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ADDR_W-1:0] tex_addr_q, tex_addr_d;
  logic              tex_rd_q, tex_rd_d;
  logic              s1_valid_q, s1_valid_d, s1_hit_q, s1_hit_d;
  logic              s2_valid_q, s2_valid_d, s2_hit_q, s2_hit_d;
  logic              pixel_valid_q, pixel_valid_d;
  logic [7:0]        color_q, color_d;

  logic [COORD_W:0]  x_ext;
  logic              in_win;
  logic [U_W-1:0]    u;
  logic [V_W-1:0]    v;

  assign scroll_y = acc_q[ACC_W-1 -: COORD_W];

  // The row sum wraps at the screen coordinate width before scaling, so the texture
  // tiles seamlessly as the scroll position rolls over.
  assign x_ext  = {1'b0, bus.requested_x};
  assign in_win = (x_ext >= WIN_LO) && (x_ext < WIN_HI);
  assign u      = U_W'((x_ext - WIN_LO) >> SCALE_LOG2);
  assign v      = V_W'((bus.requested_y + scroll_y) >> SCALE_LOG2);

  always_comb begin
    acc_d = acc_q;
    if (load_scroll)
      acc_d = {load_value, {SPEED_FRAC{1'b0}}};
    else if (frame_start && scroll_en)
      acc_d = acc_q - ACC_W'(player_speed);

    tex_rd_d   = bus.req_valid && in_win;
    tex_addr_d = tex_rd_d ? {v, u} : tex_addr_q;
    s1_valid_d = bus.req_valid;
    s1_hit_d   = in_win;
    s2_valid_d = s1_valid_q;
    s2_hit_d   = s1_hit_q;

    pixel_valid_d = s2_valid_q;
    color_d       = color_q;
    if (s2_valid_q)
      color_d = s2_hit_q ? bus.tex_data : MASK_VALUE;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      acc_q         <= '0;
      tex_addr_q    <= '0;
      tex_rd_q      <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_hit_q      <= 1'b0;
      s2_valid_q    <= 1'b0;
      s2_hit_q      <= 1'b0;
      pixel_valid_q <= 1'b0;
      color_q       <= MASK_VALUE;
    end else begin
      acc_q         <= acc_d;
      tex_addr_q    <= tex_addr_d;
      tex_rd_q      <= tex_rd_d;
      s1_valid_q    <= s1_valid_d;
      s1_hit_q      <= s1_hit_d;
      s2_valid_q    <= s2_valid_d;
      s2_hit_q      <= s2_hit_d;
      pixel_valid_q <= pixel_valid_d;
      color_q       <= color_d;
    end
  end

  assign bus.tex_addr     = tex_addr_q;
  assign bus.tex_rd       = tex_rd_q;
  assign bus.pixel_valid  = pixel_valid_q;
  assign bus.output_color = color_q;
endmodule

// File: tb/tb_scroll_background_engine.sv
// Bench for the scrolling background engine: directed corner cases plus random traffic,
// scored against an arithmetic model of scroll position and texel mapping.
module tb_scroll_background_engine;
  logic        clk = 1'b0;
  logic        resetN;
  logic        frame_start, scroll_en, load_scroll;
  logic [9:0]  player_speed;
  logic [10:0] load_value, scroll_y;

  scroll_background_engine_if #(.COORD_W(11), .ADDR_W(12)) bus ();

  scroll_background_engine dut (
    .clk          (clk),
    .resetN       (resetN),
    .frame_start  (frame_start),
    .scroll_en    (scroll_en),
    .player_speed (player_speed),
    .load_scroll  (load_scroll),
    .load_value   (load_value),
    .scroll_y     (scroll_y),
    .bus          (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // texture ROM with one cycle of read latency
  logic [7:0] rom [4096];
  always @(posedge clk) bus.tex_data <= rom[bus.tex_addr];

  // scoreboard state
  logic [7:0]  exp_q[$];
  int          exp_cyc_q[$];
  logic [11:0] addr_q[$];
  int          addr_cyc_q[$];
  logic [7:0]  last_color = 8'h62;
  logic [11:0] last_addr  = '0;
  int          n_vec = 0;
  int          n_fail = 0;
  int          acc_m = 0;   // scroll position in 1/128 pixel units, mod 2^18

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // driver: one call = one clock cycle of stimulus
  task automatic drive(input bit rv, input int x, input int y, input bit fs, input bit en,
                       input int spd, input bit ld, input int lv);
    int sy, u, v, a;
    @(negedge clk);
    check("scroll_y", int'(scroll_y), acc_m / 128);
    bus.req_valid   = rv;
    bus.requested_x = 11'(x);
    bus.requested_y = 11'(y);
    frame_start     = fs;
    scroll_en       = en;
    player_speed    = 10'(spd);
    load_scroll     = ld;
    load_value      = 11'(lv);
    if (rv) begin
      sy = acc_m / 128;
      if (x >= 32 && x < 544) begin
        u = ((x - 32) / 4) % 128;
        v = (((y + sy) % 2048) / 4) % 32;
        a = v * 128 + u;
        addr_q.push_back(12'(a));
        addr_cyc_q.push_back(cyc);
        exp_q.push_back(rom[a]);
      end else begin
        exp_q.push_back(8'h62);
      end
      exp_cyc_q.push_back(cyc);
    end
    if (ld)
      acc_m = lv * 128;
    else if (fs && en)
      acc_m = (acc_m - spd + 262144) % 262144;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    resetN        = 1'b0;
    bus.req_valid = 1'b0;
    frame_start   = 1'b0;
    load_scroll   = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    addr_q.delete();
    addr_cyc_q.delete();
    acc_m      = 0;
    last_color = 8'h62;
    last_addr  = '0;
    #1;
    check("rst_pixel_valid", int'(bus.pixel_valid), 0);
    check("rst_scroll_y", int'(scroll_y), 0);
    check("rst_color", int'(bus.output_color), 8'h62);
    check("rst_tex_rd", int'(bus.tex_rd), 0);
    check("rst_tex_addr", int'(bus.tex_addr), 0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
  endtask

  // monitor: pops expectations whenever the DUT presents a result
  always @(negedge clk) begin
    if (resetN === 1'b1) begin
      if (bus.pixel_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", 1, 0);
        end else begin
          last_color = exp_q.pop_front();
          check("color", int'(bus.output_color), int'(last_color));
          check("pixel_latency", cyc - exp_cyc_q.pop_front(), 3);
        end
      end else begin
        check("color_hold", int'(bus.output_color), int'(last_color));
      end
      if (bus.tex_rd) begin
        if (addr_q.size() == 0) begin
          check("unexpected_tex_rd", 1, 0);
        end else begin
          last_addr = addr_q.pop_front();
          check("tex_addr", int'(bus.tex_addr), int'(last_addr));
          check("tex_latency", cyc - addr_cyc_q.pop_front(), 1);
        end
      end else begin
        check("tex_addr_hold", int'(bus.tex_addr), int'(last_addr));
      end
    end
  end

  initial begin
    resetN          = 1'b0;
    bus.req_valid   = 1'b0;
    bus.requested_x = '0;
    bus.requested_y = '0;
    frame_start     = 1'b0;
    scroll_en       = 1'b0;
    player_speed    = '0;
    load_scroll     = 1'b0;
    load_value      = '0;
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    rom[129] = 8'hA5;
    rom[130] = 8'h62;
    apply_reset();
    idle(2);

    // lookups with scroll_y = 0, window edges and vertical wrap
    drive(1, 32, 0, 0, 0, 0, 0, 0);
    drive(1, 36, 4, 0, 0, 0, 0, 0);
    drive(1, 40, 4, 0, 0, 0, 0, 0);
    drive(1, 31, 0, 0, 0, 0, 0, 0);
    drive(1, 544, 0, 0, 0, 0, 0, 0);
    drive(1, 543, 0, 0, 0, 0, 0, 0);
    drive(1, 32, 124, 0, 0, 0, 0, 0);
    drive(1, 32, 128, 0, 0, 0, 0, 0);
    idle(4);

    // scroll stepping, enable gating, load priority
    drive(0, 0, 0, 1, 1, 256, 0, 0);
    drive(0, 0, 0, 1, 0, 256, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 1, 64, 0, 0);
    drive(0, 0, 0, 1, 1, 64, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 2044);
    drive(1, 32, 4, 0, 0, 0, 0, 0);
    drive(1, 36, 4, 1, 1, 256, 1, 100);
    drive(1, 36, 4, 0, 0, 0, 0, 0);
    idle(4);

    // back-to-back burst, then reset with requests in flight
    for (int i = 0; i < 30; i++)
      drive(1, $urandom_range(0, 700), $urandom_range(0, 2047), 0, 0, 0, 0, 0);
    apply_reset();
    idle(5);

    // random traffic with frame pulses and loads
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 700), $urandom_range(0, 2047),
            $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1023),
            $urandom_range(0, 49) == 0, $urandom_range(0, 2047));
    idle(6);

    check("pixel_queue_drained", exp_q.size(), 0);
    check("tex_queue_drained", addr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
